// File: rtl/eth_pkg.sv
// eth_pkg: shared constants, types and header byte offsets for the Ethernet RX parser.
package eth_pkg;

    localparam logic [15:0] ETH_ARP  = 16'h0806;
    localparam logic [15:0] ETH_IPV4 = 16'h0800;

    localparam int OFF_DST   = 0;
    localparam int OFF_SRC   = 6;
    localparam int OFF_TYPE  = 12;
    localparam int OFF_HTYPE = 14;
    localparam int OFF_OPER  = 20;
    localparam int OFF_SHA   = 22;
    localparam int OFF_SPA   = 28;
    localparam int OFF_THA   = 32;
    localparam int OFF_TPA   = 38;
    localparam int OFF_END   = 42;

    typedef enum logic [1:0] {PKT_NONE, PKT_ARP, PKT_IPV4, PKT_OTHER} pkt_type_t;

    typedef enum logic [2:0] {
        S_WAIT_IDLE, S_IDLE, S_HDR, S_ARP, S_SKIP, S_DROP, S_END
    } state_t;

    function automatic logic in_fld(input logic [10:0] idx, input int off, input int len);
        return int'(idx) >= off && int'(idx) < off + len;
    endfunction

endpackage

// File: rtl/eth_rx_parser.sv
// eth_rx_parser: parses Ethernet/ARP headers from the post-SFD byte stream, filters by MAC, counts drops.
module eth_rx_parser #(
    parameter int          MAX_LEN  = 1518,
    parameter logic [15:0] ETH_ARP  = eth_pkg::ETH_ARP,
    parameter logic [15:0] ETH_IPV4 = eth_pkg::ETH_IPV4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_rx_dv,
    input  logic [7:0]  i_rx_data,
    input  logic [47:0] i_local_mac,
    output logic [47:0] o_dst_mac,
    output logic [47:0] o_src_mac,
    output logic [1:0]  o_operation,
    output logic [47:0] o_SHA,
    output logic [31:0] o_SPA,
    output logic [47:0] o_THA,
    output logic [31:0] o_TPA,
    output logic [1:0]  o_pkt_type,
    output logic [15:0] o_drop_cnt
);
    import eth_pkg::*;

    localparam logic [10:0] BC_MAX = 11'(MAX_LEN);
    localparam logic [10:0] BC_SAT = 11'(MAX_LEN + 1);

    state_t      state, state_nx;
    logic [10:0] bc, idx;
    logic [7:0]  prev;
    logic [47:0] w_dst, w_src, w_sha, w_tha;
    logic [31:0] w_spa, w_tpa;
    logic [15:0] w_type, pair;
    logic [1:0]  w_oper;
    logic        start, in_frame, cap, dst_bad, arp_bad, accept, drop_end;
    pkt_type_t   type_nx;

    // A byte seen in IDLE or END opens a new frame and is byte 0.
    assign start    = i_rx_dv && (state == S_IDLE || state == S_END);
    assign in_frame = state == S_HDR || state == S_ARP || state == S_SKIP;
    assign idx      = start ? '0 : bc;
    assign cap      = start || (i_rx_dv && (state == S_HDR || state == S_ARP));
    assign pair     = {prev, i_rx_data};
    assign dst_bad  = w_dst != i_local_mac && w_dst != '1;
    assign arp_bad  = (idx == 11'(OFF_HTYPE + 1) && pair != 16'h0001) ||
                      (idx == 11'(OFF_HTYPE + 3) && pair != 16'h0800) ||
                      (idx == 11'(OFF_HTYPE + 4) && i_rx_data != 8'd6) ||
                      (idx == 11'(OFF_HTYPE + 5) && i_rx_data != 8'd4) ||
                      (idx == 11'(OFF_OPER + 1) && pair != 16'h0001 && pair != 16'h0002);
    assign accept   = !i_rx_dv && bc <= BC_MAX &&
                      (state == S_SKIP || (state == S_ARP && bc >= 11'(OFF_END)));
    assign drop_end = !i_rx_dv && (state == S_DROP || (in_frame && !accept));
    assign type_nx  = state == S_ARP ? PKT_ARP : w_type == ETH_IPV4 ? PKT_IPV4 : PKT_OTHER;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_WAIT_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_WAIT_IDLE:  state_nx = i_rx_dv ? S_WAIT_IDLE : S_IDLE;
            S_IDLE, S_END: state_nx = i_rx_dv ? S_HDR : S_IDLE;
            S_HDR:        state_nx = !i_rx_dv ? S_END :
                                     idx != 11'(OFF_HTYPE - 1) ? S_HDR :
                                     dst_bad ? S_DROP :
                                     pair == ETH_ARP ? S_ARP : S_SKIP;
            S_ARP:        state_nx = !i_rx_dv ? S_END : arp_bad ? S_DROP : S_ARP;
            S_SKIP:       state_nx = i_rx_dv ? S_SKIP : S_END;
            S_DROP:       state_nx = i_rx_dv ? S_DROP : S_IDLE;
            default:      state_nx = S_WAIT_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bc         <= '0;
            o_drop_cnt <= '0;
        end else begin
            bc <= start ? 11'd1 : (i_rx_dv && in_frame) ? (bc == BC_SAT ? bc : bc + 11'd1) : '0;
            if (drop_end && o_drop_cnt != '1) o_drop_cnt <= o_drop_cnt + 16'd1;
        end
    end

    // Working registers shift in their bytes as they pass; only OPER[1:0] is kept from byte 21.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev   <= '0;
            w_dst  <= '0;
            w_src  <= '0;
            w_type <= '0;
            w_oper <= '0;
            w_sha  <= '0;
            w_spa  <= '0;
            w_tha  <= '0;
            w_tpa  <= '0;
        end else if (cap) begin
            prev <= i_rx_data;
            if (in_fld(idx, OFF_DST, 6))      w_dst  <= {w_dst[39:0], i_rx_data};
            if (in_fld(idx, OFF_SRC, 6))      w_src  <= {w_src[39:0], i_rx_data};
            if (in_fld(idx, OFF_TYPE, 2))     w_type <= {w_type[7:0], i_rx_data};
            if (in_fld(idx, OFF_OPER + 1, 1)) w_oper <= i_rx_data[1:0];
            if (in_fld(idx, OFF_SHA, 6))      w_sha  <= {w_sha[39:0], i_rx_data};
            if (in_fld(idx, OFF_SPA, 4))      w_spa  <= {w_spa[23:0], i_rx_data};
            if (in_fld(idx, OFF_THA, 6))      w_tha  <= {w_tha[39:0], i_rx_data};
            if (in_fld(idx, OFF_TPA, 4))      w_tpa  <= {w_tpa[23:0], i_rx_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_pkt_type  <= PKT_NONE;
            o_dst_mac   <= '0;
            o_src_mac   <= '0;
            o_operation <= '0;
            o_SHA       <= '0;
            o_SPA       <= '0;
            o_THA       <= '0;
            o_TPA       <= '0;
        end else begin
            o_pkt_type <= accept ? type_nx : PKT_NONE;
            if (accept) begin
                o_dst_mac   <= w_dst;
                o_src_mac   <= w_src;
                o_operation <= state == S_ARP ? w_oper : '0;
                o_SHA       <= state == S_ARP ? w_sha : '0;
                o_SPA       <= state == S_ARP ? w_spa : '0;
                o_THA       <= state == S_ARP ? w_tha : '0;
                o_TPA       <= state == S_ARP ? w_tpa : '0;
            end
        end
    end

endmodule

// File: tb/tb_eth_rx_parser.sv
// tb_eth_rx_parser: randomized scoreboard bench for eth_rx_parser against a frame-level reference model.
module tb_eth_rx_parser;

    localparam logic [47:0] LM = 48'h02_11_22_33_44_55;
    localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;

    typedef struct packed {
        logic [1:0]  ptype;
        logic [47:0] dst;
        logic [47:0] src;
        logic [1:0]  oper;
        logic [47:0] sha;
        logic [31:0] spa;
        logic [47:0] tha;
        logic [31:0] tpa;
        logic [15:0] drops;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_dv = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic [47:0] local_mac = LM;
    logic [47:0] dst_mac, src_mac, sha, tha;
    logic [31:0] spa, tpa;
    logic [1:0]  operation, pkt_type;
    logic [15:0] drop_cnt;

    exp_t        sb[$];
    exp_t        last = '0;
    exp_t        mon_e;
    logic [7:0]  fr[$];
    logic [15:0] exp_drops = 16'd0;
    logic        dv_d1 = 1'b0, dv_d2 = 1'b0;
    int          n_cmp = 0, n_bad = 0;

    eth_rx_parser dut (
        .clk(clk), .rst_n(rst_n), .i_rx_dv(rx_dv), .i_rx_data(rx_data), .i_local_mac(local_mac),
        .o_dst_mac(dst_mac), .o_src_mac(src_mac), .o_operation(operation), .o_SHA(sha),
        .o_SPA(spa), .o_THA(tha), .o_TPA(tpa), .o_pkt_type(pkt_type), .o_drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every strobe pops one expected frame; timing must be one cycle after dv first falls.
    always @(negedge clk) begin
        if (rst_n && pkt_type != 2'b00) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_strobe: got type %0d expected no strobe", pkt_type);
            end else begin
                mon_e = sb.pop_front();
                chk("strobe_timing", {46'd0, dv_d2, dv_d1}, 48'd2);
                chk("pkt_type", pkt_type, mon_e.ptype);
                chk("dst_mac", dst_mac, mon_e.dst);
                chk("src_mac", src_mac, mon_e.src);
                chk("operation", operation, mon_e.oper);
                chk("sha", sha, mon_e.sha);
                chk("spa", spa, mon_e.spa);
                chk("tha", tha, mon_e.tha);
                chk("tpa", tpa, mon_e.tpa);
                chk("drop_cnt_at_strobe", drop_cnt, mon_e.drops);
            end
        end
        dv_d2 = dv_d1;
        dv_d1 = rx_dv;
    end

    function automatic logic [47:0] get(input int off, input int n);
        logic [47:0] v = '0;
        for (int i = 0; i < n; i++) v = {v[39:0], (off + i < fr.size()) ? fr[off + i] : 8'h00};
        return v;
    endfunction

    // Reference model: decides the whole frame's fate from its byte list.
    task automatic model();
        int          len;
        logic [47:0] dst;
        logic [15:0] et;
        logic        arp, drop;
        exp_t        e;
        len  = fr.size();
        dst  = get(0, 6);
        et   = 16'(get(12, 2));
        arp  = len >= 14 && et == 16'h0806;
        drop = len < 14 || len > 1518 || (dst != LM && dst != BCAST);
        if (arp)
            drop = drop || len < 42 || get(14, 2) != 48'h1 || get(16, 2) != 48'h0800 ||
                   get(18, 1) != 48'h6 || get(19, 1) != 48'h4 || !(get(20, 2) inside {48'h1, 48'h2});
        if (drop) begin
            if (exp_drops != 16'hFFFF) exp_drops++;
        end else begin
            e = '0;
            e.ptype = arp ? 2'd1 : et == 16'h0800 ? 2'd2 : 2'd3;
            e.dst   = dst;
            e.src   = get(6, 6);
            e.drops = exp_drops;
            if (arp) begin
                e.oper = 2'(get(21, 1));
                e.sha  = get(22, 6);
                e.spa  = 32'(get(28, 4));
                e.tha  = get(32, 6);
                e.tpa  = 32'(get(38, 4));
            end
            sb.push_back(e);
            last = e;
        end
    endtask

    task automatic put(input logic [47:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) fr.push_back(v[i*8 +: 8]);
    endtask

    task automatic build(input logic [47:0] dst, input logic [15:0] et, input int len,
                         input logic [15:0] htype, input logic [15:0] ptype, input logic [15:0] hlpl,
                         input logic [15:0] oper, input logic [47:0] s_ha, input logic [31:0] s_pa);
        fr.delete();
        put(dst, 6);
        put(48'({$urandom, $urandom}), 6);
        put(et, 2);
        if (et == 16'h0806) begin
            put(htype, 2);
            put(ptype, 2);
            put(hlpl, 2);
            put(oper, 2);
            put(s_ha, 6);
            put(s_pa, 4);
            put(48'({$urandom, $urandom}), 6);
            put(48'($urandom), 4);
        end
        while (fr.size() < len) fr.push_back(8'($urandom));
        while (fr.size() > len) void'(fr.pop_back());
    endtask

    task automatic send(input int gap);
        model();
        foreach (fr[i]) begin
            @(posedge clk); #1;
            rx_dv   = 1'b1;
            rx_data = fr[i];
        end
        @(posedge clk); #1;
        rx_dv   = 1'b0;
        rx_data = 8'($urandom);
        repeat (gap - 1) @(posedge clk);
    endtask

    task automatic arp(input logic [47:0] dst, input int len, input logic [15:0] ptype,
                       input logic [15:0] oper, input logic [47:0] s_ha, input logic [31:0] s_pa);
        build(dst, 16'h0806, len, 16'h0001, ptype, 16'h0604, oper, s_ha, s_pa);
    endtask

    task automatic plain(input logic [47:0] dst, input logic [15:0] et, input int len);
        build(dst, et, len, 16'h0, 16'h0, 16'h0, 16'h0, 48'h0, 32'h0);
    endtask

    task automatic rand_frame();
        int          k, j;
        logic [47:0] d;
        logic [15:0] op;
        k  = $urandom_range(0, 7);
        j  = $urandom_range(0, 4);
        d  = ($urandom_range(0, 1) != 0) ? LM : BCAST;
        op = 16'($urandom_range(1, 2));
        case (k)
            0: arp(d, $urandom_range(42, 70), 16'h0800, op, 48'({$urandom, $urandom}), $urandom);
            1: plain(d, 16'h0800, $urandom_range(14, 100));
            2: plain(d, 16'h88CC, $urandom_range(14, 80));
            3: plain(48'h0A00_0000_0000 | 48'($urandom), 16'h0800, 60);
            4: arp(d, $urandom_range(14, 41), 16'h0800, op, 48'({$urandom, $urandom}), $urandom);
            5: build(d, 16'h0806, 42, j == 0 ? 16'h0002 : 16'h0001, j == 1 ? 16'h86DD : 16'h0800,
                     j == 2 ? 16'h0804 : j == 3 ? 16'h0606 : 16'h0604, j == 4 ? 16'h0003 : op,
                     48'({$urandom, $urandom}), $urandom);
            6: plain(d, 16'h0800, $urandom_range(1, 13));
            default: arp(d, 42, 16'h0800, 16'($urandom_range(0, 3)), 48'({$urandom, $urandom}), $urandom);
        endcase
        send($urandom_range(1, 3));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_pkt_type", pkt_type, 48'h0);
        chk("rst_dst", dst_mac, 48'h0);
        chk("rst_src", src_mac, 48'h0);
        chk("rst_oper", operation, 48'h0);
        chk("rst_sha", sha, 48'h0);
        chk("rst_spa", spa, 48'h0);
        chk("rst_tha", tha, 48'h0);
        chk("rst_tpa", tpa, 48'h0);
        chk("rst_drop_cnt", drop_cnt, 48'h0);

        arp(BCAST, 42, 16'h0800, 16'h0001, 48'h02_00_00_00_00_01, 32'hC0A8_0001);
        send(3);
        plain(LM, 16'h0800, 60);
        send(2);
        plain(48'h0A_0B_0C_0D_0E_0F, 16'h0800, 60);
        send(2);
        arp(LM, 30, 16'h0800, 16'h0001, 48'h02_00_00_00_00_07, 32'h0A00_0007);
        send(2);
        @(negedge clk);
        chk("hold_dst", dst_mac, last.dst);
        chk("hold_src", src_mac, last.src);
        chk("hold_drop_cnt", drop_cnt, exp_drops);

        arp(BCAST, 42, 16'h86DD, 16'h0001, 48'h02_00_00_00_00_09, 32'h0A00_0009);
        send(2);
        plain(LM, 16'h0800, 1600);
        send(2);
        plain(LM, 16'h88B5, 1519);
        send(2);
        plain(LM, 16'h88B5, 1518);
        send(2);
        plain(BCAST, 16'h0800, 1518);
        send(2);

        arp(BCAST, 42, 16'h0800, 16'h0001, 48'h02_00_00_00_00_AA, 32'hC0A8_00AA);
        send(1);
        arp(LM, 50, 16'h0800, 16'h0002, 48'h02_00_00_00_00_BB, 32'hC0A8_00BB);
        send(3);

        arp(LM, 42, 16'h0800, 16'h0001, 48'h02_00_00_00_00_CC, 32'hC0A8_00CC);
        foreach (fr[i]) begin
            @(posedge clk); #1;
            rx_dv   = 1'b1;
            rx_data = fr[i];
            if (i == 10) rst_n = 1'b0;
            if (i == 13) rst_n = 1'b1;
        end
        exp_drops = 16'd0;
        last      = '0;
        chk("midrst_drop_cnt", drop_cnt, 48'h0);
        @(posedge clk); #1 rx_dv = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("midrst_dst", dst_mac, 48'h0);
        chk("midrst_drop_after", drop_cnt, 48'h0);
        arp(LM, 42, 16'h0800, 16'h0002, 48'h02_00_00_00_00_DD, 32'hC0A8_00DD);
        send(3);

        repeat (40) rand_frame();

        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("sb_empty", 48'(sb.size()), 48'h0);
        chk("final_drop_cnt", drop_cnt, exp_drops);
        chk("final_dst", dst_mac, last.dst);
        chk("final_src", src_mac, last.src);
        chk("final_sha", sha, last.sha);
        chk("final_tpa", tpa, last.tpa);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
